// File: rtl/core_regs_mp.sv
// core_regs_mp -- multi-port integer register file with a load-pending scoreboard.
//
// Two write ports (A: EX/ALU result, B: load return), NUM_RD combinational
// read ports and one pending bit per register so the decoder can see which
// operands are still waiting on a load. Register 0 always reads 0 and is
// never pending.
//
// Optional feature: define REGS_BYPASS_EN to forward same-cycle write data
// (port A over port B) onto rdata. A same-cycle load return also clears
// rd_busy, unless sb_set marks that register pending again in that cycle.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset (clears all state)
//   we_a/waddr_a/wdata_a  write port A (wins on same-address collision)
//   we_b/waddr_b/wdata_b  write port B (also clears the pending bit)
//   sb_set/sb_set_addr  mark a register pending (set wins over a B clear)
//   raddr               packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rdata               packed read data,      port i at [i*DATA_W +: DATA_W]
//   rd_busy             pending flag of each read port's register
//   any_busy            OR of rd_busy
module core_regs_mp #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_NUM = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned NUM_RD  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_a,
  input  logic [ADDR_W-1:0]        waddr_a,
  input  logic [DATA_W-1:0]        wdata_a,
  input  logic                     we_b,
  input  logic [ADDR_W-1:0]        waddr_b,
  input  logic [DATA_W-1:0]        wdata_b,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_set_addr,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     any_busy
);

  logic [DATA_W-1:0]  regs [REG_NUM];
  logic [REG_NUM-1:0] pending;

  logic en_a, en_b, en_set;

  assign en_a   = we_a   && (waddr_a     != '0);
  assign en_b   = we_b   && (waddr_b     != '0);
  assign en_set = sb_set && (sb_set_addr != '0);

  // Port B is applied first so a same-address port A write overrides it;
  // likewise the scoreboard set follows the clear so a new load wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        regs[i] <= '0;
      end
      pending <= '0;
    end else begin
      if (en_b) begin
        regs[waddr_b]    <= wdata_b;
        pending[waddr_b] <= 1'b0;
      end
      if (en_a) begin
        regs[waddr_a] <= wdata_a;
      end
      if (en_set) begin
        pending[sb_set_addr] <= 1'b1;
      end
    end
  end

  logic [ADDR_W-1:0] ra;
  logic [DATA_W-1:0] rd;
  logic              bz;

  always_comb begin
    rdata   = '0;
    rd_busy = '0;
    ra      = '0;
    rd      = '0;
    bz      = 1'b0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      ra = raddr[i*ADDR_W +: ADDR_W];
      rd = regs[ra];
      bz = pending[ra];
`ifdef REGS_BYPASS_EN
      // Writes are ignored during reset, so nothing is forwarded then.
      if (!rst) begin
        if (en_b && (waddr_b == ra)) begin
          rd = wdata_b;
          if (!(en_set && (sb_set_addr == ra))) begin
            bz = 1'b0;
          end
        end
        if (en_a && (waddr_a == ra)) begin
          rd = wdata_a;
        end
      end
`endif
      if (ra == '0) begin
        rd = '0;
        bz = 1'b0;
      end
      rdata[i*DATA_W +: DATA_W] = rd;
      rd_busy[i]                = bz;
    end
  end

  assign any_busy = |rd_busy;

endmodule

// File: tb/tb_core_regs_mp.sv
module tb_core_regs_mp;

`ifdef REGS_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        we_a, we_b, sb_set;
  logic [4:0]  waddr_a, waddr_b, sb_set_addr;
  logic [31:0] wdata_a, wdata_b;
  logic [9:0]  raddr2;
  logic [19:0] raddr4;
  logic [63:0] rdata2;
  logic [127:0] rdata4;
  logic [1:0]  busy2;
  logic [3:0]  busy4;
  logic        any2, any4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  core_regs_mp dut (
    .clk(clk), .rst(rst),
    .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a),
    .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b),
    .sb_set(sb_set), .sb_set_addr(sb_set_addr),
    .raddr(raddr2), .rdata(rdata2), .rd_busy(busy2), .any_busy(any2)
  );

  core_regs_mp #(.NUM_RD(4)) dut4 (
    .clk(clk), .rst(rst),
    .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a),
    .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b),
    .sb_set(sb_set), .sb_set_addr(sb_set_addr),
    .raddr(raddr4), .rdata(rdata4), .rd_busy(busy4), .any_busy(any4)
  );

  // Reference model: architectural register contents and pending flags.
  logic [31:0] mreg [32];
  logic        mpend [32];

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 32; k++) begin
        mreg[k]  <= '0;
        mpend[k] <= 1'b0;
      end
    end else begin
      if (we_a && waddr_a != 0) mreg[waddr_a] <= wdata_a;
      if (we_b && waddr_b != 0 && !(we_a && waddr_a == waddr_b)) mreg[waddr_b] <= wdata_b;
      for (int k = 1; k < 32; k++) begin
        if (sb_set && sb_set_addr == k)  mpend[k] <= 1'b1;
        else if (we_b && waddr_b == k)   mpend[k] <= 1'b0;
      end
    end
  end

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (a == 0) return '0;
    if (BYP && !rst && we_a && waddr_a == a) return wdata_a;
    if (BYP && !rst && we_b && waddr_b == a) return wdata_b;
    return mreg[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 0) return 1'b0;
    if (BYP && !rst && we_b && waddr_b == a && !(sb_set && sb_set_addr == a)) return 1'b0;
    return mpend[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic bor;
    bor = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("m2_data", rdata2[i*32 +: 32], exp_data(raddr2[i*5 +: 5]));
      check("m2_busy", {31'd0, busy2[i]}, {31'd0, exp_busy(raddr2[i*5 +: 5])});
      bor = bor | exp_busy(raddr2[i*5 +: 5]);
    end
    check("m2_any", {31'd0, any2}, {31'd0, bor});
    bor = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("m4_data", rdata4[i*32 +: 32], exp_data(raddr4[i*5 +: 5]));
      check("m4_busy", {31'd0, busy4[i]}, {31'd0, exp_busy(raddr4[i*5 +: 5])});
      bor = bor | exp_busy(raddr4[i*5 +: 5]);
    end
    check("m4_any", {31'd0, any4}, {31'd0, bor});
  endtask

  task automatic idle();
    rst = 1'b0; we_a = 1'b0; we_b = 1'b0; sb_set = 1'b0;
    waddr_a = '0; waddr_b = '0; sb_set_addr = '0;
    wdata_a = '0; wdata_b = '0;
  endtask

  task automatic set_reads(input logic [4:0] r0, input logic [4:0] r1);
    raddr2 = {r1, r0};
    raddr4 = {r0 ^ 5'd1, 5'd7, r1, r0};
  endtask

  typedef struct {
    logic        rst;
    logic        wea; logic [4:0] wa; logic [31:0] da;
    logic        web; logic [4:0] wb; logic [31:0] db;
    logic        sbs; logic [4:0] sba;
    logic [4:0]  ra0, ra1;
    logic [31:0] ed0, ed1;
    logic        eb0, eb1;
  } vec_t;

  function automatic vec_t mk(input logic r,
                              input logic wea, input logic [4:0] wa, input logic [31:0] da,
                              input logic web, input logic [4:0] wb, input logic [31:0] db,
                              input logic sbs, input logic [4:0] sba,
                              input logic [4:0] ra0, input logic [4:0] ra1,
                              input logic [31:0] ed0, input logic [31:0] ed1,
                              input logic eb0, input logic eb1);
    vec_t v;
    v.rst = r; v.wea = wea; v.wa = wa; v.da = da; v.web = web; v.wb = wb; v.db = db;
    v.sbs = sbs; v.sba = sba; v.ra0 = ra0; v.ra1 = ra1;
    v.ed0 = ed0; v.ed1 = ed1; v.eb0 = eb0; v.eb1 = eb1;
    return v;
  endfunction

  vec_t vecs [14];

  initial begin
    // Each row: apply inputs over one edge, then read back with writes idle.
    vecs[0]  = mk(0, 1, 5, 32'hDEADBEEF, 0, 0, 0,            0, 0, 5, 0, 32'hDEADBEEF, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0,            0, 0, 0,            0, 0, 5, 5, 0, 0, 0, 0);
    vecs[2]  = mk(1, 1, 6, 32'h1,        0, 0, 0,            1, 6, 5, 6, 0, 0, 0, 0);
    vecs[3]  = mk(0, 1, 0, 32'h1234,     1, 0, 32'h5678,     1, 0, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mk(0, 1, 7, 32'hAAAA0000, 1, 7, 32'h5555FFFF, 0, 0, 7, 7, 32'hAAAA0000, 32'hAAAA0000, 0, 0);
    vecs[5]  = mk(0, 1, 3, 32'h11,       1, 4, 32'h22,       0, 0, 3, 4, 32'h11, 32'h22, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0,            0, 0, 0,            1, 9, 9, 3, 0, 32'h11, 1, 0);
    vecs[7]  = mk(0, 0, 0, 0,            1, 9, 32'hCAFE,     0, 0, 9, 9, 32'hCAFE, 32'hCAFE, 0, 0);
    vecs[8]  = mk(0, 0, 0, 0,            1, 9, 32'hBEEF,     1, 9, 9, 4, 32'hBEEF, 32'h22, 1, 0);
    vecs[9]  = mk(0, 0, 0, 0,            0, 0, 0,            1, 9, 9, 0, 32'hBEEF, 0, 1, 0);
    vecs[10] = mk(0, 1, 9, 32'h1111,     0, 0, 0,            0, 0, 9, 7, 32'h1111, 32'hAAAA0000, 1, 0);
    vecs[11] = mk(0, 0, 0, 0,            0, 0, 0,            1, 2, 2, 9, 0, 32'h1111, 1, 1);
    vecs[12] = mk(1, 0, 0, 0,            0, 0, 0,            0, 0, 2, 9, 0, 0, 0, 0);
    vecs[13] = mk(0, 0, 0, 0,            1, 2, 32'h77,       0, 0, 2, 0, 32'h77, 0, 0, 0);

    idle();
    set_reads(5'd0, 5'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    idle();
    #1;
    check("reset_any", {31'd0, any2}, 32'd0);
    check_model();

    foreach (vecs[n]) begin
      @(negedge clk);
      rst = vecs[n].rst;
      we_a = vecs[n].wea; waddr_a = vecs[n].wa; wdata_a = vecs[n].da;
      we_b = vecs[n].web; waddr_b = vecs[n].wb; wdata_b = vecs[n].db;
      sb_set = vecs[n].sbs; sb_set_addr = vecs[n].sba;
      @(negedge clk);
      idle();
      set_reads(vecs[n].ra0, vecs[n].ra1);
      #1;
      check($sformatf("vec%0d_d0", n), rdata2[31:0],  vecs[n].ed0);
      check($sformatf("vec%0d_d1", n), rdata2[63:32], vecs[n].ed1);
      check($sformatf("vec%0d_b0", n), {31'd0, busy2[0]}, {31'd0, vecs[n].eb0});
      check($sformatf("vec%0d_b1", n), {31'd0, busy2[1]}, {31'd0, vecs[n].eb1});
      check($sformatf("vec%0d_any", n), {31'd0, any2}, {31'd0, vecs[n].eb0 | vecs[n].eb1});
      check_model();
    end

    // Read-during-write on x12.
    @(negedge clk);
    idle(); we_a = 1'b1; waddr_a = 5'd12; wdata_a = 32'h10;
    @(negedge clk);
    idle(); we_a = 1'b1; waddr_a = 5'd12; wdata_a = 32'h42;
    set_reads(5'd12, 5'd12);
    #1;
    check("rdw_same_cycle", rdata2[31:0], BYP ? 32'h42 : 32'h10);
    check_model();
    @(negedge clk);
    idle();
    #1;
    check("rdw_next_cycle", rdata2[31:0], 32'h42);

    // Load return to a pending register, with and without a re-mark.
    @(negedge clk);
    idle(); sb_set = 1'b1; sb_set_addr = 5'd13;
    @(negedge clk);
    idle(); we_b = 1'b1; waddr_b = 5'd13; wdata_b = 32'h98;
    sb_set = 1'b1; sb_set_addr = 5'd13;
    set_reads(5'd13, 5'd12);
    #1;
    check("remark_busy", {31'd0, busy2[0]}, 32'd1);
    check("remark_data", rdata2[31:0], BYP ? 32'h98 : 32'h0);
    check_model();
    @(negedge clk);
    idle(); we_b = 1'b1; waddr_b = 5'd13; wdata_b = 32'h99;
    #1;
    check("ret_busy", {31'd0, busy2[0]}, BYP ? 32'd0 : 32'd1);
    check("ret_data", rdata2[31:0], BYP ? 32'h99 : 32'h98);
    check_model();
    @(negedge clk);
    idle();
    #1;
    check("ret_after_busy", {31'd0, busy2[0]}, 32'd0);
    check("ret_after_data", rdata2[31:0], 32'h99);

    // Randomized traffic over a small address window to force collisions.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      idle();
      if ($urandom_range(0, 24) == 0) begin
        rst = 1'b1;
      end else begin
        we_a = 1'($urandom_range(0, 1)); waddr_a = 5'($urandom_range(0, 15)); wdata_a = $urandom;
        we_b = 1'($urandom_range(0, 1)); waddr_b = 5'($urandom_range(0, 15)); wdata_b = $urandom;
        sb_set = 1'($urandom_range(0, 1)); sb_set_addr = 5'($urandom_range(0, 15));
      end
      raddr2 = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
      raddr4 = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
                5'($urandom_range(0, 15)), 5'($urandom_range(0, 31))};
      #1;
      check_model();
    end

    @(negedge clk);
    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
